// File: rtl/cu_pkg.sv
// Shared control-unit definitions: microstore address width, next-address
// codes carried in each microinstruction, and default vectors. Used by the
// microsequencer, the microstore and the instruction decoder.
package cu_pkg;

  localparam int UADDR_W = 7;

  // Next-address codes (n_code field of the microinstruction)
  localparam logic [2:0] N_DISPATCH = 3'b000;
  localparam logic [2:0] N_INC      = 3'b001;
  localparam logic [2:0] N_JUMP     = 3'b010;
  localparam logic [2:0] N_COND     = 3'b011;
  localparam logic [2:0] N_WAIT     = 3'b100;
  localparam logic [2:0] N_CALL     = 3'b101;
  localparam logic [2:0] N_RETURN   = 3'b110;
  localparam logic [2:0] N_RESTART  = 3'b111;

  localparam logic [UADDR_W-1:0] DEF_RESET_VECTOR = 7'h00;
  localparam logic [UADDR_W-1:0] DEF_FAULT_ADDR   = 7'h7F;

  // Sequential successor; wraps 7F -> 00 through natural width truncation.
  function automatic logic [UADDR_W-1:0] uaddr_inc(input logic [UADDR_W-1:0] a);
    return a + 7'd1;
  endfunction

endpackage

// File: rtl/cu_next_addr_mux.sv
// Purely combinational next-address selection for the microsequencer.
// Ports:
//   n_code      next-address type of the current microinstruction
//   cr_addr     target-address field
//   inv         inverts cond_true for conditional branch
//   dec_addr    decoder dispatch address
//   cond_true   condition-tester result
//   moc         memory operation complete
//   index       current micro-PC
//   ret_addr    saved return address
//   wait_cnt    cycles already spent in the current memory wait
//   next        selected next micro-PC
//   fault       wait timeout in this cycle
//   wait_hold   wait continues (counter should advance)
//   wait_active stalled in a memory wait
module cu_next_addr_mux
  import cu_pkg::*;
#(
  parameter int                 MOC_TIMEOUT  = 15,
  parameter logic [UADDR_W-1:0] FAULT_ADDR   = DEF_FAULT_ADDR,
  parameter logic [UADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic [2:0]         n_code,
  input  logic [UADDR_W-1:0] cr_addr,
  input  logic               inv,
  input  logic [UADDR_W-1:0] dec_addr,
  input  logic               cond_true,
  input  logic               moc,
  input  logic [UADDR_W-1:0] index,
  input  logic [UADDR_W-1:0] ret_addr,
  input  logic [7:0]         wait_cnt,
  output logic [UADDR_W-1:0] next,
  output logic               fault,
  output logic               wait_hold,
  output logic               wait_active
);

  localparam logic [7:0] LAST_WAIT = 8'(MOC_TIMEOUT - 1);

  logic [UADDR_W-1:0] w_inc;
  logic               w_timeout;

  assign w_inc       = uaddr_inc(index);
  assign wait_active = (n_code == N_WAIT) & ~moc;
  // moc wins over timeout because wait_active already excludes moc.
  assign w_timeout   = wait_active & (wait_cnt == LAST_WAIT);

  always_comb begin
    next      = w_inc;
    fault     = 1'b0;
    wait_hold = 1'b0;
    unique case (n_code)
      N_DISPATCH: next = dec_addr;
      N_INC:      next = w_inc;
      N_JUMP:     next = cr_addr;
      N_COND:     next = (cond_true ^ inv) ? cr_addr : w_inc;
      N_WAIT: begin
        if (moc) begin
          next = w_inc;
        end else if (w_timeout) begin
          next  = FAULT_ADDR;
          fault = 1'b1;
        end else begin
          next      = index;
          wait_hold = 1'b1;
        end
      end
      N_CALL:     next = cr_addr;
      N_RETURN:   next = ret_addr;
      N_RESTART:  next = RESET_VECTOR;
      default:    next = w_inc;
    endcase
  end

endmodule

// File: rtl/cu_microsequencer.sv
// Control-unit microsequencer: holds the micro-PC that indexes the microstore
// and advances it each cycle according to the microinstruction's
// next-address code. Also holds a single-entry return register and the
// memory-wait timeout counter.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   n_code       next-address type (from microinstruction)
//   cr_addr      target-address field (from microinstruction)
//   inv          inverts cond_true for code 011
//   dec_addr     decoder dispatch address
//   cond_true    condition-tester result
//   moc          memory operation complete
//   index        registered micro-PC, drives microstore index
//   wait_active  high while stalled in a memory wait (combinational)
//   fault        one-cycle pulse on wait timeout (combinational)
module cu_microsequencer
  import cu_pkg::*;
#(
  parameter int                 MOC_TIMEOUT  = 15,
  parameter logic [UADDR_W-1:0] FAULT_ADDR   = DEF_FAULT_ADDR,
  parameter logic [UADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         n_code,
  input  logic [UADDR_W-1:0] cr_addr,
  input  logic               inv,
  input  logic [UADDR_W-1:0] dec_addr,
  input  logic               cond_true,
  input  logic               moc,
  output logic [UADDR_W-1:0] index,
  output logic               wait_active,
  output logic               fault
);

  logic [UADDR_W-1:0] r_index;
  logic [UADDR_W-1:0] r_ret;
  logic [7:0]         r_wait_cnt;

  logic [UADDR_W-1:0] w_next;
  logic               w_fault;
  logic               w_wait_hold;
  logic               w_wait_active;

  cu_next_addr_mux #(
    .MOC_TIMEOUT  (MOC_TIMEOUT),
    .FAULT_ADDR   (FAULT_ADDR),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_mux (
    .n_code      (n_code),
    .cr_addr     (cr_addr),
    .inv         (inv),
    .dec_addr    (dec_addr),
    .cond_true   (cond_true),
    .moc         (moc),
    .index       (r_index),
    .ret_addr    (r_ret),
    .wait_cnt    (r_wait_cnt),
    .next        (w_next),
    .fault       (w_fault),
    .wait_hold   (w_wait_hold),
    .wait_active (w_wait_active)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index    <= RESET_VECTOR;
      r_ret      <= RESET_VECTOR;
      r_wait_cnt <= 8'd0;
    end else begin
      r_index <= w_next;
      if (n_code == N_CALL) r_ret <= uaddr_inc(r_index);
      // Counter only survives a cycle that keeps holding in the wait;
      // moc, timeout and any other code clear it.
      r_wait_cnt <= w_wait_hold ? r_wait_cnt + 8'd1 : 8'd0;
    end
  end

  assign index       = r_index;
  assign wait_active = w_wait_active;
  assign fault       = w_fault;

endmodule
